// File: rtl/bcd_convert_sched.sv
// Shared binary-to-BCD engine: four requesters arbitrated round-robin onto one
// iterative shift-add-3 datapath; results are clamped to SAT_VALUE and channel-tagged.
module bcd_convert_sched #(
   parameter int WIDTH     = 14,
   parameter int SAT_VALUE = 9999
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic [3:0]           req,
   input  logic [4*WIDTH-1:0]   bin_in,
   output logic [3:0]           ack,
   output logic                 busy,
   output logic [15:0]          bcd_out,
   output logic [1:0]           bcd_ch,
   output logic                 bcd_valid,
   output logic                 bcd_ovf
);

   localparam int               CNT_W     = $clog2(WIDTH);
   localparam logic [WIDTH-1:0] SAT       = WIDTH'(SAT_VALUE);
   localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

   typedef enum logic {IDLE, SHIFT} state_t;

   state_t           state, state_next;
   logic [1:0]       last, grant, idx;
   logic             grant_vld, start, done;
   logic [3:0]       ack_next;
   logic [WIDTH-1:0] bin_sel, load_val, sh;
   logic             load_ovf, ovf;
   logic [15:0]      acc, acc_adj, acc_next;
   logic [CNT_W-1:0] cnt;

   // Round-robin search starts just after the last winner.
   always_comb begin
      // NOTE: every combinational output gets a default first so no path infers a latch.
      grant_vld = 1'b0;
      grant     = last;
      idx       = last;
      for (int i = 1; i <= 4; i++) begin
         idx = last + 2'(i);
         if (!grant_vld && req[idx]) begin
            grant_vld = 1'b1;
            grant     = idx;
         end
      end
   end

   // One double-dabble step: adjust all nibbles in parallel, then shift in the next MSB.
   always_comb begin
      acc_adj = '0;
      for (int n = 0; n < 4; n++) begin
         acc_adj[n*4 +: 4] = (acc[n*4 +: 4] >= 4'd5) ? acc[n*4 +: 4] + 4'd3 : acc[n*4 +: 4];
      end
      acc_next = {acc_adj[14:0], sh[WIDTH-1]};
   end

   // State register
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state uses non-blocking assignments so all registers update together.
      if (!rst_n) state <= IDLE;
      else        state <= state_next;
   end

   // Next-state logic
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (grant_vld) state_next = SHIFT;
         SHIFT:   if (cnt == LAST_ITER) state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output / control decode
   always_comb begin
      start    = (state == IDLE) && grant_vld;
      done     = (state == SHIFT) && (cnt == LAST_ITER);
      ack_next = start ? (4'b0001 << grant) : 4'b0000;
      bin_sel  = bin_in[grant*WIDTH +: WIDTH];
      load_ovf = bin_sel > SAT;
      load_val = load_ovf ? SAT : bin_sel;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the datapath is only a handful of flops, so all of it is reset; an abort leaves no stale state.
      if (!rst_n) begin
         last      <= 2'd3;
         sh        <= '0;
         ovf       <= 1'b0;
         acc       <= '0;
         cnt       <= '0;
         ack       <= '0;
         busy      <= 1'b0;
         bcd_out   <= '0;
         bcd_ch    <= '0;
         bcd_valid <= 1'b0;
         bcd_ovf   <= 1'b0;
      end else begin
         ack       <= ack_next;
         bcd_valid <= done;
         if (start) begin
            last <= grant;
            sh   <= load_val;
            ovf  <= load_ovf;
            acc  <= '0;
            cnt  <= '0;
            busy <= 1'b1;
         end else if (state == SHIFT) begin
            acc <= acc_next;
            sh  <= {sh[WIDTH-2:0], 1'b0};
            cnt <= cnt + CNT_W'(1);
         end
         if (done) begin
            bcd_out <= acc_next;
            bcd_ch  <= last;
            bcd_ovf <= ovf;
            busy    <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_bcd_convert_sched.sv
// Scoreboard bench for bcd_convert_sched: a round-robin arbitration model predicts grants
// and pushes decimal-arithmetic expectations; an independent monitor pops them on bcd_valid.
module tb_bcd_convert_sched;

   localparam int W = 14;

   logic           clk = 1'b0;
   logic           rst_n = 1'b0;
   logic [3:0]     req;
   logic [4*W-1:0] bin_in;
   logic [3:0]     ack;
   logic           busy;
   logic [15:0]    bcd_out;
   logic [1:0]     bcd_ch;
   logic           bcd_valid;
   logic           bcd_ovf;

   typedef struct {
      logic [1:0]  ch;
      logic [15:0] bcd;
      logic        ovf;
      int          gcyc;
   } exp_t;

   exp_t        sb[$];
   int          test_cnt = 0;
   int          fail_cnt = 0;
   int          cyc = 0;
   int          raise_cnt[4] = '{default: 0};
   int          serve_cnt[4] = '{default: 0};
   logic [3:0]  hold = 4'b0000;
   int          m_last = 3;
   logic        have_grant = 1'b0;
   int          grant_cyc = 0;
   logic [15:0] last_bcd = '0;
   logic [1:0]  last_ch = '0;
   logic        last_ovf = 1'b0;

   bcd_convert_sched #(.WIDTH(W), .SAT_VALUE(9999)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req       (req),
      .bin_in    (bin_in),
      .ack       (ack),
      .busy      (busy),
      .bcd_out   (bcd_out),
      .bcd_ch    (bcd_ch),
      .bcd_valid (bcd_valid),
      .bcd_ovf   (bcd_ovf)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // A requester holds its line from being raised until its own ack is seen.
   always_comb begin
      for (int i = 0; i < 4; i++) req[i] = hold[i] || (raise_cnt[i] > serve_cnt[i]);
   end

   function automatic logic [15:0] to_bcd(int v);
      int s;
      s = (v > 9999) ? 9999 : v;
      return {4'(s / 1000), 4'((s / 100) % 10), 4'((s / 10) % 10), 4'(s % 10)};
   endfunction

   task automatic check(string name, logic [31:0] act, logic [31:0] exp);
      test_cnt++;
      if (act !== exp) begin
         fail_cnt++;
         $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
      end
   endtask

   task automatic raise(int ch, int val);
      bin_in[ch*W +: W] = W'(val);
      raise_cnt[ch]     = serve_cnt[ch] + 1;
   endtask

   task automatic wait_done(int bound);
      int n;
      n = 0;
      while ((sb.size() != 0 || req != 4'b0 || busy) && n < bound) begin
         @(negedge clk);
         n++;
      end
      check("drain_in_time", 32'(n < bound), 32'd1);
   endtask

   task automatic wait_ack(int ch, int bound);
      int n;
      n = 0;
      do begin
         @(posedge clk);
         #1;
         n++;
      end while (!ack[ch] && n < bound);
      check("ack_seen", 32'(ack[ch]), 32'd1);
   endtask

   // Arbitration model: predicts every ack, records expectations, retires requests.
   always @(posedge clk) begin
      logic [3:0] exp_ack;
      logic       found;
      int         g, c, v;
      #1;
      if (!rst_n) begin
         m_last     = 3;
         have_grant = 1'b0;
      end else begin
         exp_ack = 4'b0;
         found   = 1'b0;
         g       = 0;
         if (!have_grant || (cyc - grant_cyc) >= 15) begin
            for (int k = 1; k <= 4; k++) begin
               c = (m_last + k) % 4;
               if (!found && req[c]) begin
                  found = 1'b1;
                  g     = c;
               end
            end
         end
         if (found) exp_ack[g] = 1'b1;
         check("ack", 32'(ack), 32'(exp_ack));
         if (found) begin
            v = int'(bin_in[g*W +: W]);
            sb.push_back('{2'(g), to_bcd(v), v > 9999, cyc});
            m_last     = g;
            have_grant = 1'b1;
            grant_cyc  = cyc;
            serve_cnt[g]++;
         end
         check("busy", 32'(busy), 32'(have_grant && (cyc - grant_cyc) < 14));
      end
   end

   // Result monitor: pops on every bcd_valid, otherwise checks the outputs hold.
   always @(posedge clk) begin
      exp_t e;
      #1;
      if (!rst_n) begin
         sb.delete();
         last_bcd = '0;
         last_ch  = '0;
         last_ovf = 1'b0;
      end else if (bcd_valid) begin
         if (sb.size() == 0) begin
            check("unexpected_valid", 32'(bcd_valid), 32'd0);
         end else begin
            e = sb.pop_front();
            check("bcd_out", 32'(bcd_out), 32'(e.bcd));
            check("bcd_ch", 32'(bcd_ch), 32'(e.ch));
            check("bcd_ovf", 32'(bcd_ovf), 32'(e.ovf));
            check("latency", 32'(cyc - e.gcyc), 32'd14);
         end
         last_bcd = bcd_out;
         last_ch  = bcd_ch;
         last_ovf = bcd_ovf;
      end else begin
         check("hold", {13'b0, bcd_ovf, bcd_ch, bcd_out}, {13'b0, last_ovf, last_ch, last_bcd});
      end
   end

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish at cycle %0d", cyc);
      $fatal(1);
   end

   initial begin
      int bvals[4] = '{0, 9999, 10000, 16383};
      int ch, v;
      bin_in = '0;
      rst_n  = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("reset_state", {7'b0, ack, busy, bcd_out, bcd_ch, bcd_valid, bcd_ovf}, 32'd0);
      @(negedge clk) rst_n = 1'b1;

      // Single conversion on channel 2
      @(negedge clk) raise(2, 1234);
      wait_done(100);

      // Boundary values on channel 0
      foreach (bvals[i]) begin
         @(negedge clk) raise(0, bvals[i]);
         wait_done(100);
      end

      // All four requesting at once
      @(negedge clk);
      for (int i = 0; i < 4; i++) raise(i, int'($urandom_range(0, 16383)));
      wait_done(200);

      // Two permanently held requesters must alternate
      @(negedge clk);
      bin_in[0 +: W] = W'(1111);
      bin_in[W +: W] = W'(2222);
      hold = 4'b0011;
      repeat (100) @(negedge clk);
      hold = 4'b0000;
      wait_done(100);

      // Input change after grant must not disturb the conversion
      @(negedge clk) raise(1, 500);
      repeat (3) @(negedge clk);
      bin_in[W +: W] = W'(7777);
      wait_done(100);

      // Reset in the middle of a conversion
      @(negedge clk) raise(3, 4321);
      wait_ack(3, 20);
      repeat (7) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("abort_reset", {7'b0, ack, busy, bcd_out, bcd_ch, bcd_valid, bcd_ovf}, 32'd0);
      for (int i = 0; i < 4; i++) raise_cnt[i] = serve_cnt[i];
      repeat (2) @(posedge clk);
      @(negedge clk) rst_n = 1'b1;
      @(negedge clk);
      raise(0, 42);
      raise(3, 8765);
      wait_done(200);

      // Randomized traffic
      for (int i = 0; i < 40; i++) begin
         @(negedge clk);
         ch = int'($urandom_range(0, 3));
         v  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(10000, 16383))
                                          : int'($urandom_range(0, 9999));
         if (!req[ch]) raise(ch, v);
         repeat ($urandom_range(0, 20)) @(negedge clk);
      end
      wait_done(1000);

      $display("[TB] %0d tests run, %0d failed", test_cnt, fail_cnt);
      $finish;
   end

endmodule

// File: doc/bcd_convert_sched.md
Name: bcd_convert_sched

Overview:
Shared, time-multiplexed binary-to-BCD conversion engine for the fitness-tracker display path. Four requesters share one iterative shift-add-3 (double-dabble) datapath through round-robin arbitration and a req/ack handshake. The requesters are step count, distance, calories and active time. Each result is returned as four packed BCD digits, tagged with the channel ID, for the 7-segment display driver.

Parameters:
WIDTH, 14, binary input width per channel; this equals the number of shift iterations per conversion.
SAT_VALUE, 9999, largest value that can be displayed; larger inputs are clamped to this value.

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req  input  4  per-channel conversion request; level, held until ack
bin_in  input  4*WIDTH  packed channel values; channel n is bin_in[n*WIDTH +: WIDTH]
ack  output  4  one-hot, one-cycle pulse: the request was captured
busy  output  1  high while a conversion is in flight
bcd_out  output  16  result digits {thousands, hundreds, tens, ones}
bcd_ch  output  2  channel that owns bcd_out
bcd_valid  output  1  one-cycle pulse: bcd_out/bcd_ch/bcd_ovf updated
bcd_ovf  output  1  result was clamped to SAT_VALUE

Behaviour:
- Reset (asynchronous, active-low) forces the following:
  - ack=0, busy=0, bcd_out=0, bcd_ch=0, bcd_valid=0, bcd_ovf=0.
  - State=IDLE, round-robin pointer last=3, so channel 0 has top priority first.
- States are IDLE and SHIFT.
- IDLE, at edge E0 with any req bit high:
  - The granted channel g is the first requesting channel in the order last+1, last+2, last+3, last (mod 4).
  - Capture bin_in for channel g. If the value exceeds SAT_VALUE, load SAT_VALUE and set an internal ovf flag; otherwise load the value and clear ovf.
  - Clear the 16-bit digit accumulator. Set last=g, busy=1, state=SHIFT.
  - ack[g]=1 for exactly the cycle following E0.
- IDLE with req=0: nothing changes; busy=0.
- SHIFT runs one iteration per edge, E1..E_WIDTH, taking binary bits MSB first:
  - Each nibble of the accumulator that is >=5 has 3 added to it (all four nibbles evaluated in parallel, same cycle).
  - The accumulator then shifts left by 1, with the next binary MSB shifted into bit 0.
- At edge E_WIDTH (E14 with defaults):
  - bcd_out takes the final accumulator value; bcd_ch=g; bcd_ovf=ovf.
  - bcd_valid=1 for one cycle; busy=0; state=IDLE.
- Latency and throughput:
  - Grant edge to bcd_valid is WIDTH edges (14).
  - The next grant can occur no earlier than edge E_WIDTH+1, so one conversion completes every WIDTH+1 cycles at best.
- Handshake rules:
  - req is ignored while busy.
  - A requester must drop req in the cycle it observes ack. If req is still high when the block returns to IDLE, it is treated as a new request.
  - bin_in of a channel is sampled only at its grant edge; later changes do not affect an in-flight conversion.
- Output hold: bcd_out, bcd_ch and bcd_ovf keep their values between bcd_valid pulses.
- Arithmetic:
  - The accumulator is 16 bits, so 4 digits is sufficient for SAT_VALUE<=9999. No digit ever exceeds 9.
  - An input of 0 yields 0x0000.
- Simultaneous events: a request arriving on the same edge that completes a conversion is not arbitrated until the next edge.
- Reset mid-conversion: the conversion is aborted. No bcd_valid is produced, prior bcd_out is cleared to 0, and the pointer returns to 3.

Test Plan:
- Reset, then req[2]=1 with ch2=1234: ack=0100 for one cycle after the grant edge; bcd_valid 14 edges after grant; bcd_out=0x1234, bcd_ch=2, bcd_ovf=0, busy low after valid.
- Boundary values on ch0, one at a time:
  - 0 gives 0x0000, ovf=0.
  - 9999 gives 0x9999, ovf=0.
  - 10000 gives 0x9999, ovf=1.
  - 16383 gives 0x9999, ovf=1.
- After reset, all req=1111 held and each bit dropped on its ack: grants in the order 0,1,2,3; bcd_valid pulses spaced 15 cycles apart; bcd_ch sequence 0,1,2,3; no ack during busy.
- Fairness: req[0] held permanently, req[1] held permanently from cycle 0: grants alternate 0,1,0,1; neither channel is granted twice in a row while the other is pending.
- Assert rst_n low at SHIFT iteration 7 of a ch3 conversion of 4321: outputs go to 0 immediately and no bcd_valid appears. After release, req=1001 grants ch0 first.
- Change ch1's bin_in from 500 to 7777 during SHIFT: the result is still 0x0500.
